// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MULDIV_W     = 32;
  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } muldiv_state_t;

  // Unsigned magnitude of an operand; raw bits for unsigned ops.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [MULDIV_W-1:0] magnitude(input logic [MULDIV_W-1:0] v,
                                                    input logic is_signed);
    return (is_signed && v[MULDIV_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division,
// both one bit per cycle over a shared 64-bit accumulator.
// Build option: define MULDIV_DIV_EN to include the divider; without it a
// DIV/DIVU start goes straight to FIX, pulses done and leaves HI/LO alone.
// Handshake: start is sampled only in IDLE; busy is high while the unit
// cannot accept MTHI/MTLO; done pulses for one cycle when HI/LO take a result
// (busy is already low in that cycle, so a new start may be issued then).
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = MULDIV_W  // must equal MULDIV_W / MULDIV_ITERS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                we_hi,
  input  logic                we_lo,
  input  logic [WIDTH-1:0]    wd,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo,
  output muldiv_state_t       dbg_state
);

  localparam int CW = $clog2(MULDIV_ITERS) + 1;
  localparam logic [CW-1:0] LAST = CW'(MULDIV_ITERS);

  muldiv_state_t      state, state_nx;
  logic [2*WIDTH-1:0] acc;       // {upper, lower}: product or {remainder, quotient}
  logic [WIDTH-1:0]   bop;       // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;   // product / quotient sign
  logic               signed_op;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef MULDIV_DIV_EN
  logic               neg_rem;   // remainder follows the dividend
  logic               div_zero;
  logic [WIDTH:0]     div_r;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  assign signed_op = ~op[0];
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: 32 working cycles plus one terminal cycle in MUL/DIV.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_nx = op[1] ? DIV : MUL;
`else
          state_nx = op[1] ? FIX : MUL;
`endif
        end
      end
      MUL, DIV: if (cnt == LAST) state_nx = FIX;
      FIX:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Per-step arithmetic and sign correction of the final accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? bop : {WIDTH{1'b0}})};
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
`ifdef MULDIV_DIV_EN
    div_r   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge  = (div_r >= {1'b0, bop});
    div_sub = div_r[WIDTH-1:0] - bop;
    // A zero divisor leaves |a| in the remainder, so the corrected HI is a.
    quo_fix = div_zero ? {WIDTH{1'b1}}
                       : (neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0]);
    rem_fix = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
`endif
  end

  // Operand latch at start and one iteration per MUL/DIV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      bop     <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            is_div  <= op[1];
            neg_res <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            neg_rem  <= signed_op & a[WIDTH-1];
            div_zero <= (b == '0);
`endif
            if (op[1]) begin
              acc <= {{WIDTH{1'b0}}, magnitude(a, signed_op)};
              bop <= magnitude(b, signed_op);
            end else begin
              acc <= {{WIDTH{1'b0}}, magnitude(b, signed_op)};
              bop <= magnitude(a, signed_op);
            end
          end
        end
        MUL: begin
          if (cnt != LAST) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
          end
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          if (cnt != LAST) begin
            if (div_ge) acc <= {div_sub,            acc[WIDTH-2:0], 1'b1};
            else        acc <= {div_r[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0};
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // HI/LO, busy and done: MTHI/MTLO while not busy, results on FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
      busy <= (state == MUL) || (state == DIV);
      if (!busy) begin
        if (we_hi) hi <= wd;
        if (we_lo) lo <= wd;
      end
      if (state == FIX) begin
`ifdef MULDIV_DIV_EN
        if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
`else
        if (!is_div) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result scoreboard.
// Divider vectors run when MULDIV_DIV_EN is defined; otherwise the
// divider-removed behaviour is exercised instead.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          we_hi = 1'b0;
  logic          we_lo = 1'b0;
  logic [W-1:0]  wd = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  muldiv_state_t dbg_state;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_v;
  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wd(wd), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done hi=0x%08h lo=0x%08h", hi, lo);
      end else begin
        exp_v = exp_q.pop_front();
        check("result_hi", hi, exp_v[2*W-1:W]);
        check("result_lo", lo, exp_v[W-1:0]);
      end
    end
  end

  // Issue one operation, queue its result, check latency and busy length.
  task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int elat, input int ebusy);
    int lat;
    int nb;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = av; b = bv;
    exp_q.push_back({eh, el});
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    nb = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (busy) nb++;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({name, "_latency"}, W'(lat), W'(elat));
    check({name, "_busy_cycles"}, W'(nb), W'(ebusy));
  endtask

  // MTHI (sel_hi=1) or MTLO write, then check visibility after the edge.
  task automatic mt_write(input logic sel_hi, input logic [W-1:0] v);
    @(posedge clk); #1;
    we_hi = sel_hi; we_lo = ~sel_hi; wd = v;
    @(posedge clk); #1;
    we_hi = 1'b0; we_lo = 1'b0;
    if (sel_hi) check("mthi", hi, v);
    else        check("mtlo", lo, v);
  endtask

  initial begin
    int lat;
    int ndone;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_state", W'(dbg_state), W'(IDLE));
    rst_n = 1'b1;

    // Multiply vectors.
    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 33);
    do_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 33);
    do_op("mult_minx2", OP_MULT, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000, 34, 33);
    do_op("multu_shift", OP_MULTU, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 34, 33);
    do_op("mult_7xneg6", OP_MULT, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 34, 33);

`ifdef MULDIV_DIV_EN
    // Divide vectors, including divide-by-zero and the signed overflow case.
    do_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33);
    do_op("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 34, 33);
    do_op("div_neg5by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 34, 33);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 33);
    do_op("divu_100by7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 33);
    do_op("div_7byneg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, 33);
`endif

    // Start and MTLO while busy are both ignored.
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
    exp_q.push_back({32'd0, 32'd12});
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 9)  begin start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3; end
      if (i == 10) start = 1'b0;
      if (i == 11) begin we_lo = 1'b1; wd = 32'hAA; end
      if (i == 12) we_lo = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("ignore_latency", W'(lat), W'(34));
    repeat (40) @(posedge clk);
    #1;
    check("ignore_lo_hold", lo, 32'd12);

    // Reset mid-operation aborts with no done pulse.
    @(posedge clk); #1;
`ifdef MULDIV_DIV_EN
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
`else
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_state", W'(dbg_state), W'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", W'(ndone), '0);
    mt_write(1'b1, 32'h55);

`ifndef MULDIV_DIV_EN
    // Divider removed: DIV completes in one cycle and leaves HI/LO alone.
    mt_write(1'b1, 32'h33);
    mt_write(1'b0, 32'h7);
    do_op("div_removed", OP_DIV, 32'd100, 32'd3, 32'h33, 32'h7, 1, 0);
    do_op("divu_removed", OP_DIVU, 32'd9, 32'd0, 32'h33, 32'h7, 1, 0);
    do_op("multu_after", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 34, 33);
`endif

    // Final report.
    repeat (5) @(posedge clk);
    #1;
    check("exp_q_drained", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
